// File: rtl/acdc_avg_ctrl_pkg.sv
// Shared constants and divider state encoding for the AC/DC coupling average controller.
package acdc_pkg;
    localparam int WIDTH  = 8;
    localparam int WINDOW = 640;
    localparam int CNT_W  = 10;
    localparam int SUM_W  = 18;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_RUN  = 2'd1,
        D_DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/acdc_avg_ctrl_seq_udiv.sv
// Restoring unsigned divider by a constant: one quotient bit per cycle, DIV_W cycles,
// start accepted only in D_IDLE; quotient is valid while state == D_DONE.
module seq_udiv import acdc_pkg::*; #(
    parameter int DIV_W   = 18,
    parameter int DIVISOR = 640
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [DIV_W-1:0] dividend,
    output logic [DIV_W-1:0] quotient,
    output div_state_t       state
);
    // The remainder is always below DIVISOR, so it fits in $clog2(DIVISOR) bits.
    localparam int REM_W = $clog2(DIVISOR) + 1;
    localparam int BIT_W = $clog2(DIV_W);

    logic [REM_W-2:0] rem;
    logic [REM_W-2:0] rem_nx;
    logic [REM_W-1:0] rem_sh;
    logic             ge;
    logic [BIT_W-1:0] bit_cnt;

    always_comb begin
        rem_sh = {rem, quotient[DIV_W-1]};
        ge     = rem_sh >= REM_W'(DIVISOR);
        rem_nx = ge ? (REM_W-1)'(rem_sh - REM_W'(DIVISOR)) : rem_sh[REM_W-2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= D_IDLE;
            bit_cnt <= '0;
        end else if (clear) begin
            state   <= D_IDLE;
            bit_cnt <= '0;
        end else begin
            case (state)
                D_IDLE: begin
                    bit_cnt <= '0;
                    if (start) state <= D_RUN;
                end
                D_RUN: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BIT_W'(DIV_W - 1)) state <= D_DONE;
                end
                D_DONE:  state <= D_IDLE;
                default: state <= D_IDLE;
            endcase
        end
    end

    // Dividend shifts out of the top while quotient bits shift in at the bottom.
    always_ff @(posedge clk) begin
        if (state == D_IDLE && start) begin
            quotient <= dividend;
            rem      <= '0;
        end else if (state == D_RUN) begin
            quotient <= {quotient[DIV_W-2:0], ge};
            rem      <= rem_nx;
        end
    end
endmodule

// File: rtl/acdc_avg_ctrl.sv
// AC/DC coupling controller: accumulates WINDOW samples, divides by WINDOW in the background,
// publishes the mean as avg and gates the coupling mode until a first mean exists.
module acdc_avg_ctrl #(
    parameter int WIDTH  = acdc_pkg::WIDTH,
    parameter int WINDOW = acdc_pkg::WINDOW,
    parameter int CNT_W  = acdc_pkg::CNT_W,
    parameter int SUM_W  = acdc_pkg::SUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             clear,
    input  logic             mode_req,
    output logic [WIDTH-1:0] avg,
    output logic             avg_update,
    output logic             avg_valid,
    output logic             mode,
    output logic             busy
);
    import acdc_pkg::*;

    function automatic logic [WIDTH-1:0] sat_avg(input logic [SUM_W-1:0] q);
        if (q > SUM_W'((2 ** WIDTH) - 1)) return '1;
        return q[WIDTH-1:0];
    endfunction

    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] sum_nx;
    logic             last;
    logic             load;
    logic [SUM_W-1:0] quotient;
    div_state_t       div_st;

    always_comb begin
        sum_nx = sum + SUM_W'(sample);
        last   = count == CNT_W'(WINDOW - 1);
        load   = sample_valid && !clear && last;
    end

    // Accumulation stage: the next window starts while the previous one is being divided.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            count <= '0;
        end else if (clear) begin
            sum   <= '0;
            count <= '0;
        end else if (sample_valid) begin
            if (last) begin
                sum   <= '0;
                count <= '0;
            end else begin
                sum   <= sum_nx;
                count <= count + 1'b1;
            end
        end
    end

    seq_udiv #(
        .DIV_W   (SUM_W),
        .DIVISOR (WINDOW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (load),
        .clear    (clear),
        .dividend (sum_nx),
        .quotient (quotient),
        .state    (div_st)
    );

    assign busy = div_st == D_RUN;

    // Publish stage: mode sees avg_valid one cycle late, so it rises after the first update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg        <= '0;
            avg_update <= 1'b0;
            avg_valid  <= 1'b0;
            mode       <= 1'b0;
        end else begin
            avg_update <= 1'b0;
            if (div_st == D_DONE && !clear) begin
                avg        <= sat_avg(quotient);
                avg_update <= 1'b1;
                avg_valid  <= 1'b1;
            end
            mode <= mode_req && avg_valid;
        end
    end
endmodule

// File: tb/tb_acdc_avg_ctrl.sv
// Directed bench for acdc_avg_ctrl with a timestamped scoreboard of expected mean updates.
module tb_acdc_avg_ctrl;
    localparam int WINDOW = 640;
    localparam int SUM_W  = 18;
    localparam int LAT    = SUM_W + 2;
    localparam int PER    = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_valid;
    logic [7:0] sample;
    logic       clear;
    logic       mode_req;
    logic [7:0] avg;
    logic       avg_update;
    logic       avg_valid;
    logic       mode;
    logic       busy;

    typedef struct {
        logic [7:0] v;
        time        t;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    time  last_edge = 0;

    always #(PER/2) clk = ~clk;

    acdc_avg_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .clear        (clear),
        .mode_req     (mode_req),
        .avg          (avg),
        .avg_update   (avg_update),
        .avg_valid    (avg_valid),
        .mode         (mode),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && avg_update === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_update: got update with avg %0d, required none (t=%0t)", avg, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("avg", {24'd0, avg}, {24'd0, e.v});
                chk("update_time", 32'($time), 32'(e.t));
                chk("avg_valid_at_update", {31'd0, avg_valid}, 32'd1);
            end
        end
    end

    task automatic put(input logic [7:0] s);
        @(posedge clk);
        last_edge = $time;
        #1;
        sample_valid = 1'b1;
        sample       = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
        end
    endtask

    task automatic window(input logic [7:0] a, input logic [7:0] b, input int gap,
                          input bit exp_on, input logic [7:0] ev);
        for (int i = 0; i < WINDOW; i++) begin
            put((i % 2) ? b : a);
            if (gap > 0) idle(gap);
        end
        if (exp_on) sb.push_back('{v: ev, t: last_edge + LAT*PER + PER/2});
    endtask

    task automatic pulse_clear(input logic sv, input logic [7:0] s);
        @(posedge clk);
        #1;
        clear        = 1'b1;
        sample_valid = sv;
        sample       = s;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        sample_valid = 1'b0;
    endtask

    initial begin
        #(PER * 50000);
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; sample_valid = 1'b0; sample = '0; clear = 1'b0; mode_req = 1'b1;
        #12;
        chk("rst_avg", {24'd0, avg}, 32'd0);
        chk("rst_avg_update", {31'd0, avg_update}, 32'd0);
        chk("rst_avg_valid", {31'd0, avg_valid}, 32'd0);
        chk("rst_mode", {31'd0, mode}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        chk("mode_before_mean", {31'd0, mode}, 32'd0);

        window(8'd100, 8'd100, 0, 1'b1, 8'd100);
        idle(1);
        chk("busy_run", {31'd0, busy}, 32'd1);
        #(last_edge + LAT*PER + PER/2 - $time);
        chk("first_update_pulse", {31'd0, avg_update}, 32'd1);
        chk("mode_at_first_update", {31'd0, mode}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd0);
        #(PER);
        chk("mode_after_first_update", {31'd0, mode}, 32'd1);
        chk("update_one_cycle", {31'd0, avg_update}, 32'd0);
        idle(5);

        window(8'd0, 8'd200, 0, 1'b1, 8'd100);
        idle(25);
        window(8'd255, 8'd255, 0, 1'b1, 8'd255);
        idle(25);
        window(8'd100, 8'd100, 2, 1'b1, 8'd100);
        idle(25);

        @(posedge clk); #1 mode_req = 1'b0;
        @(posedge clk); #1 chk("mode_req_off", {31'd0, mode}, 32'd0);
        mode_req = 1'b1;
        @(posedge clk); #1 chk("mode_req_on", {31'd0, mode}, 32'd1);

        for (int i = 0; i < 300; i++) put(8'd77);
        pulse_clear(1'b1, 8'd255);
        window(8'd50, 8'd50, 0, 1'b1, 8'd50);
        idle(25);
        chk("avg_after_clear_window", {24'd0, avg}, 32'd50);

        window(8'd30, 8'd30, 0, 1'b0, 8'd0);
        idle(5);
        chk("busy_before_clear", {31'd0, busy}, 32'd1);
        pulse_clear(1'b0, 8'd0);
        chk("busy_after_clear", {31'd0, busy}, 32'd0);
        idle(25);
        chk("avg_kept_after_clear", {24'd0, avg}, 32'd50);
        chk("avg_valid_kept", {31'd0, avg_valid}, 32'd1);

        window(8'd10, 8'd10, 0, 1'b1, 8'd10);
        window(8'd20, 8'd20, 0, 1'b1, 8'd20);
        idle(25);
        chk("avg_back_to_back", {24'd0, avg}, 32'd20);

        window(8'd40, 8'd40, 0, 1'b0, 8'd0);
        idle(5);
        #3 rst_n = 1'b0;
        #1;
        chk("async_avg", {24'd0, avg}, 32'd0);
        chk("async_avg_valid", {31'd0, avg_valid}, 32'd0);
        chk("async_mode", {31'd0, mode}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        window(8'd7, 8'd7, 0, 1'b1, 8'd7);
        idle(25);
        chk("avg_after_reset", {24'd0, avg}, 32'd7);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
